mux2_sel_reg: RTL and testbench

//   Bit-sliced 2:1 selector and the base building block for wider muxes.
//   For example, a 4:1 mux is three instances in a tree: sel[0] drives the leaves, sel[1] the root.

---
 rtl/mux2_sel_reg.sv | 41 ++++
 tb/tb_mux2_sel_reg.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mux2_sel_reg.sv
// Bit-sliced 2:1 selector, usable as the leaf/root cell of wider mux trees.
// REG_OUT=1 adds an enabled output register with asynchronous clear.
module mux2_sel_reg #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] mux_d;

  // Conditional operator merges i0/i1 bitwise when sel is X, so agreeing bits stay known.
  assign mux_d = sel ? i1 : i0;

  generate
    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] out_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_q <= '0;
        end else if (en) begin
          out_q <= mux_d;
        end
      end

      assign out = out_q;
    end else begin : g_comb
      logic unused_reg_ctl;
      assign unused_reg_ctl = &{1'b0, clk, reset, en};
      assign out = mux_d;
    end
  endgenerate

endmodule

// File: tb/tb_mux2_sel_reg.sv
// Directed bench for mux2_sel_reg: combinational 1/8-bit slices, a 4:1 tree,
// and the registered variant (latency, enable hold, asynchronous clear).
module tb_mux2_sel_reg;

  logic clk;
  logic clk_idle;
  logic rst_idle;
  logic en_idle;

  int n_checks;
  int n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=1 combinational
  logic c_i0, c_i1, c_sel, c_out;
  mux2_sel_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
    .clk(clk_idle), .reset(rst_idle), .i0(c_i0), .i1(c_i1),
    .sel(c_sel), .en(en_idle), .out(c_out)
  );

  // 4:1 tree
  logic [3:0] t_in;
  logic [1:0] t_sel;
  logic       t_lo, t_hi, t_out;
  mux2_sel_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_leaf0 (
    .clk(clk_idle), .reset(rst_idle), .i0(t_in[0]), .i1(t_in[1]),
    .sel(t_sel[0]), .en(en_idle), .out(t_lo)
  );
  mux2_sel_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_leaf1 (
    .clk(clk_idle), .reset(rst_idle), .i0(t_in[2]), .i1(t_in[3]),
    .sel(t_sel[0]), .en(en_idle), .out(t_hi)
  );
  mux2_sel_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_root (
    .clk(clk_idle), .reset(rst_idle), .i0(t_lo), .i1(t_hi),
    .sel(t_sel[1]), .en(en_idle), .out(t_out)
  );

  // WIDTH=8 combinational
  logic [7:0] w_i0, w_i1, w_out;
  logic       w_sel;
  mux2_sel_reg #(.WIDTH(8), .REG_OUT(1'b0)) u_c8 (
    .clk(clk_idle), .reset(rst_idle), .i0(w_i0), .i1(w_i1),
    .sel(w_sel), .en(en_idle), .out(w_out)
  );

  // WIDTH=8 registered
  logic [7:0] r_i0, r_i1, r_out;
  logic       r_sel, r_en, r_rst;
  mux2_sel_reg #(.WIDTH(8), .REG_OUT(1'b1)) u_r8 (
    .clk(clk), .reset(r_rst), .i0(r_i0), .i1(r_i1),
    .sel(r_sel), .en(r_en), .out(r_out)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_c1;
  logic [3:0] exp_tree;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk_idle = 1'b0;
    rst_idle = 1'b0;
    en_idle  = 1'b0;

    r_rst = 1'b1;
    r_en  = 1'b1;
    r_i0  = 8'h11;
    r_i1  = 8'h22;
    r_sel = 1'b1;
    #2;
    check("reg_reset_val", r_out, 8'h00);

    // index {i0,i1,sel}: expected out for 000..111
    exp_c1 = 8'b1101_1000;
    for (int v = 0; v < 8; v++) begin
      {c_i0, c_i1, c_sel} = 3'(v);
      #1;
      check($sformatf("c1_v%0d", v), 8'(c_out), 8'(exp_c1[v]));
    end

    t_in     = 4'b1010;
    exp_tree = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      t_sel = 2'(s);
      #50;
      check($sformatf("tree_sel%0d", s), 8'(t_out), 8'(exp_tree[s]));
    end

    w_i0  = 8'hA5;
    w_i1  = 8'h3C;
    w_sel = 1'b0;
    #1;
    check("c8_sel0", w_out, 8'hA5);
    w_sel = 1'b1;
    #1;
    check("c8_sel1", w_out, 8'h3C);
    w_sel = 1'b0;
    #1;
    check("c8_toggle", w_out, 8'hA5);

    // Registered: reset held across an edge with en=1 keeps 0
    step();
    check("reg_rst_edge", r_out, 8'h00);
    @(negedge clk);
    r_rst = 1'b0;
    r_sel = 1'b0;
    step();
    check("reg_cap_i0", r_out, 8'h11);

    r_sel = 1'b1;
    #2;
    check("reg_latency_hold", r_out, 8'h11);
    step();
    check("reg_cap_i1", r_out, 8'h22);

    @(negedge clk);
    r_rst = 1'b1;
    #1;
    check("reg_async_clr", r_out, 8'h00);
    #1;
    r_rst = 1'b0;
    r_sel = 1'b0;
    step();
    check("reg_after_rst", r_out, 8'h11);

    r_en  = 1'b0;
    r_sel = 1'b1;
    r_i0  = 8'h55;
    r_i1  = 8'h66;
    step();
    check("reg_en0_edge1", r_out, 8'h11);
    r_i0 = 8'h77;
    step();
    check("reg_en0_edge2", r_out, 8'h11);
    r_sel = 1'b0;
    step();
    check("reg_en0_edge3", r_out, 8'h11);
    r_en  = 1'b1;
    r_sel = 1'b1;
    #2;
    check("reg_en1_pre", r_out, 8'h11);
    step();
    check("reg_en1_cap", r_out, 8'h66);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
